cadastro_senhas: RTL



---
 rtl/cadastro_senhas.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/cadastro_senhas.sv
// cadastro_senhas: password registration controller, writer side of the password table.
// Scans the stored entries for a duplicate, then appends the new password to the next free slot.
// Optional build macro CLEAR_ALL_EN: adds input limpar and a CLEAR state that zeroes the whole table.
module cadastro_senhas #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enter,
`ifdef CLEAR_ALL_EN
    input  logic              limpar,
`endif
    input  logic [DATA_W-1:0] senha_nova,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              ok,
    output logic              erro,
    output logic [1:0]        codigo_erro,
    output logic [ADDR_W:0]   count
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_SCAN  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;
`ifdef CLEAR_ALL_EN
    localparam logic [2:0] S_CLEAR = 3'd6;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
`endif
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [1:0] E_ZERO = 2'b01;
    localparam logic [1:0] E_FULL = 2'b10;
    localparam logic [1:0] E_DUP  = 2'b11;

    logic [2:0]        state_q, state_d;
    logic              enter_q;
    logic [DATA_W-1:0] senha_q, senha_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [1:0]        code_q, code_d;
    logic              trig;

    assign trig = enter & ~enter_q;

`ifdef CLEAR_ALL_EN
    logic limpar_q;
    logic clr_trig;

    assign clr_trig = limpar & ~limpar_q;

    // Edge register for the clear request, sampled every cycle like enter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) limpar_q <= 1'b0;
        else     limpar_q <= limpar;
    end
`endif

    // State, latched password, fill level and scan/clear index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            enter_q <= 1'b0;
            senha_q <= '0;
            count_q <= '0;
            idx_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            enter_q <= enter;
            senha_q <= senha_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
        end
    end

    // Next-state logic; during SCAN the compare at index i checks the entry addressed at i-1.
    always_comb begin
        state_d = state_q;
        senha_d = senha_q;
        count_d = count_q;
        idx_d   = idx_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (trig) begin
                    senha_d = senha_nova;
                    state_d = S_CHECK;
                end
`ifdef CLEAR_ALL_EN
                if (clr_trig) begin
                    senha_d = senha_q;
                    state_d = S_CLEAR;
                end
`endif
            end
            S_CHECK: begin
                idx_d = '0;
                if (senha_q == '0) begin
                    code_d  = E_ZERO;
                    state_d = S_ERR;
                end else if (count_q == FULL) begin
                    code_d  = E_FULL;
                    state_d = S_ERR;
                end else begin
                    state_d = (count_q == '0) ? S_WRITE : S_SCAN;
                end
            end
            S_SCAN: begin
                if (idx_q != '0 && mem_rdata == senha_q) begin
                    code_d  = E_DUP;
                    state_d = S_ERR;
                end else if (idx_q == count_q) begin
                    state_d = S_WRITE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_WRITE: begin
                count_d = (count_q == FULL) ? count_q : count_q + 1'b1;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
`ifdef CLEAR_ALL_EN
            S_CLEAR: begin
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    count_d = '0;
                    state_d = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

`ifdef CLEAR_ALL_EN
    logic clearing;
    assign clearing = (state_q == S_CLEAR);
`else
    logic clearing;
    assign clearing = 1'b0;
`endif

    assign busy        = (state_q != S_IDLE);
    assign ok          = (state_q == S_DONE);
    assign erro        = (state_q == S_ERR);
    assign codigo_erro = erro ? code_q : 2'b00;
    assign mem_we      = (state_q == S_WRITE) | clearing;
    assign mem_wdata   = (state_q == S_WRITE) ? senha_q : '0;
    assign mem_addr    = (state_q == S_WRITE) ? count_q[ADDR_W-1:0] :
                         (state_q == S_SCAN || clearing) ? idx_q[ADDR_W-1:0] : '0;
    assign count       = count_q;
endmodule
